// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: bit-serial MULT/MULTU/DIV/DIVU engine
// owning the architectural HI/LO registers.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   b_mag;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_abs;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_dif;
  logic [2*WIDTH-1:0] div_nx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign a_neg = op[0] & src_a[WIDTH-1];
  assign b_neg = op[0] & src_b[WIDTH-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_abs = b_neg ? -src_b : src_b;

  // Multiply: acc = {partial, multiplier}; add into top, shift right.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, b_mag} : '0);
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; restoring step.
  assign div_sh  = acc[2*WIDTH-1:WIDTH-1];
  assign div_dif = div_sh - {1'b0, b_mag};
  assign div_nx  = div_dif[WIDTH]
                 ? {acc[2*WIDTH-2:0], 1'b0}
                 : {div_dif[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH]
                      : acc[2*WIDTH-1:WIDTH];

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = CALC;
      CALC: begin
        if (flush)            state_nx = IDLE;
        else if (cnt == LAST) state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      a_raw  <= '0;
      b_mag  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            acc    <= {{WIDTH{1'b0}}, a_mag};
            a_raw  <= src_a;
            b_mag  <= b_abs;
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        CALC: begin
          if (!flush) begin
            cnt <= cnt + 1'b1;
            acc <= is_div ? div_nx : mul_nx;
          end
        end
        FIX: begin
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod;
            end else if (b_mag == '0) begin
              lo <= '1;
              hi <= a_raw;
            end else begin
              lo <= quo;
              hi <= rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed checks of latency, results,
// HI/LO writes, flush and reset behaviour.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called at the negedge after the start edge; waits for commit.
  task automatic finish_op(input string tag,
                           input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    int n;
    int early;
    n = 0;
    early = 0;
    while (busy === 1'b1 && n < 100) begin
      if (done === 1'b1) early++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_busycyc"}, 32'(n), 32'd33);
    chk({tag, "_early_done"}, 32'(early), 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    @(negedge clk);
    chk({tag, "_done_off"}, {31'd0, done}, 32'd0);
  endtask

  task automatic issue(input logic [1:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00;
    src_a = '0; src_b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy", {31'd0, busy}, 32'd1);
    finish_op("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    issue(2'b01, 32'hFFFF_FFF9, 32'd3);
    finish_op("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // reset in the middle of CALC
    issue(2'b00, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("midrst_done2", {31'd0, done}, 32'd0);

    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    finish_op("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(2'b10, 32'd100, 32'd0);
    finish_op("divu0", 32'd100, 32'hFFFF_FFFF);

    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("divovf", 32'd0, 32'h8000_0000);

    // MTHI in idle
    mthi = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_lo", lo, 32'h8000_0000);
    chk("mthi_done", {31'd0, done}, 32'd0);

    // MTLO coincident with start: start wins
    mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    start = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd6;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    chk("mtlo_drop", lo, 32'h8000_0000);
    finish_op("mtlo_start", 32'd0, 32'd30);

    // flush at iteration 5, then immediate restart
    issue(2'b10, 32'd1000, 32'd7);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, 32'd0);
    chk("flush_lo", lo, 32'd30);
    chk("flush_done", {31'd0, done}, 32'd0);
    start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", {31'd0, busy}, 32'd1);
    finish_op("divu", 32'd6, 32'd142);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller for the pipelined CPU's HI/LO resource. Accepts MULT/MULTU/DIV/DIVU issued from the execute stage and sequences a shared shift-add/restoring-subtract datapath one bit per cycle. Owns the HI/LO registers, services MTHI/MTLO writes and drives `busy` to the hazard logic so MFHI/MFLO and new mul/div ops stall until the result is committed.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  issue request; sampled only in IDLE.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `src_a`  in  WIDTH  multiplicand / dividend (rs).
- `src_b`  in  WIDTH  multiplier / divisor (rt).
- `mthi`, `mtlo`  in  1 each  write `wdata` into HI / LO.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `flush`  in  1  abort in-flight operation (branch/exception squash).
- `busy`  out  1  operation in flight; stall request to hazard unit.
- `done`  out  1  one-cycle pulse when HI/LO are committed from an operation.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: `start`=1 latches operands, op and sign info; for signed ops (op[0]=1) the datapath works on magnitudes. Iteration counter cleared; go to CALC.
- CALC: one iteration per cycle. Multiply: conditional add of |B| into the upper half of a 2*WIDTH accumulator, then shift right. Divide: shift remainder/quotient left, trial-subtract |B|, keep if non-negative and set quotient bit. After `WIDTH` iterations go to FIX.
- FIX: apply signs; commit HI/LO; pulse `done`; return to IDLE.
  - Multiply: {HI,LO} = product; negate the 64-bit result if operand signs differ (signed only).
  - Divide: LO = quotient, HI = remainder. Quotient is negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero (B=0, either signedness): LO = all ones, HI = `src_a` unmodified, no sign fix.
  - Signed 0x80000000 / -1: LO = 0x80000000, HI = 0 (natural magnitude result, no trap).
- `mthi`/`mtlo` are honoured only in IDLE and only when `start`=0. If `start`=1 in the same cycle, `start` wins and the writes are dropped. While busy they are ignored, because the pipeline is already stalled by `busy`.
- `start` while not IDLE is ignored.
- `flush` in CALC or FIX: return to IDLE next edge. HI/LO are unchanged, `done` stays 0. `flush` in IDLE has no effect and does not block a coincident `start`.
- `rst` has priority over all inputs.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
- `start` sampled at edge E0.
- `busy`=1 from E0 through E(WIDTH+1). It falls at the same edge that commits HI/LO: E33 for WIDTH=32, so `busy` is high for 33 cycles.
- `done`=1 for exactly the cycle following E33; new HI/LO are visible in that same cycle.
- A new `start` can be accepted at E34, i.e. back-to-back issue gives one result every 34 cycles.
- MTHI/MTLO: value visible on `hi`/`lo` the cycle after the write edge. No `done` pulse.
- `busy` is a registered output with no combinational path from `start`. The hazard unit stalls an MFHI/MFLO that is in the same cycle as an issuing op by its own decode.

## Test plan
- Reset mid-CALC (`rst` at iteration 10) -> next cycle `busy`=0, `hi`=`lo`=0, no `done`.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> after 33 busy cycles HI=0xFFFFFFFE, LO=0x00000001, `done` pulses once.
- MULT -7 * 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x1234 in IDLE -> `hi`=0x1234 next cycle. MTLO together with `start` -> LO from the op, not `wdata`. `flush` at iteration 5 -> HI/LO keep prior values, no `done`, a new `start` is accepted the following cycle.
